cache_sys_if: RTL and testbench
===============================

Name: cache_sys_if

Overview:
- System-side bus interface that sits directly downstream of the cache controller.
- Takes the controller's system strobe/RW/ready handshake and converts it into single-word memory transactions.
- Read misses become a LINE_WORDS-beat line fill, streamed word-by-word into the cache data array; it signals `readup` with the last word.
- Write-through requests become one memory write, acknowledged by a one-cycle SysReady pulse.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width (byte address step = DATA_WIDTH/8).
- LINE_WORDS, 4, words per cache line; power of two, at least 2.
- OFS_WIDTH, 2, log2(LINE_WORDS); word-offset width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- SysStrobe  in  1  request from the cache controller; one-cycle pulse.
- SysRW  in  1  `RW_READ / `RW_WRITE; sampled only with SysStrobe.
- SysAddress  in  ADDR_WIDTH  request byte address.
- SysWData  in  DATA_WIDTH  write data.
- do_buffer_flush  in  1  clears the fill counter and fill outputs.
- SysReady  out  1  one-cycle pulse: write completed.
- readup  out  1  one-cycle pulse: last fill word is on fill_* this cycle.
- fill_valid  out  1  fill_data/fill_offset are valid this cycle.
- fill_data  out  DATA_WIDTH  fill word to the cache array.
- fill_offset  out  OFS_WIDTH  word index within the line.
- MReq  out  1  memory request; held until MAck.
- MRw  out  1  memory direction.
- MAddress  out  ADDR_WIDTH  memory byte address.
- MWData  out  DATA_WIDTH  memory write data.
- MRData  in  DATA_WIDTH  memory read data; valid with MAck.
- MAck  in  1  memory accepts or completes the beat.

Behaviour:
- **Reset:** all outputs are registered. Reset forces state=IDLE and count=0. It drives MReq, SysReady, readup and fill_valid to 0, MRw=`RW_UNK, and MAddress, MWData, fill_data and fill_offset to 0.
- **Mid-operation reset:** reset during a transaction aborts it with the same values on the next edge; no late pulses follow.
- **States:** IDLE, RD_BEAT, WR_BEAT.
- **IDLE, read:** on SysStrobe with SysRW=`RW_READ:
  - latch base = SysAddress with its low OFS_WIDTH+log2(DATA_WIDTH/8) bits cleared;
  - count=0;
  - next cycle MReq=1, MRw=`RW_READ, MAddress=base;
  - go to RD_BEAT.
- **IDLE, write:** on SysStrobe with SysRW=`RW_WRITE:
  - latch SysAddress unmodified and SysWData;
  - next cycle MReq=1, MRw=`RW_WRITE;
  - go to WR_BEAT.
- **RD_BEAT:**
  - MReq, MRw and MAddress stay stable while MAck=0.
  - On MAck: fill_data<=MRData, fill_offset<=count, fill_valid<=1 for exactly one cycle.
  - If count<LINE_WORDS-1: increment count and set MAddress=base+(count+1)*(DATA_WIDTH/8); MReq stays high, giving back-to-back beats.
  - If count==LINE_WORDS-1: readup<=1 in the same cycle as the last fill_valid, MReq<=0, go to IDLE.
- **Read latency:** each word appears one cycle after its MAck. The line is complete one cycle after the LINE_WORDS-th MAck.
- **Offset order:** fill_offset runs 0..LINE_WORDS-1 strictly in order; no critical-word-first, no wrap.
- **WR_BEAT:** on MAck, MReq<=0, SysReady<=1 for one cycle, go to IDLE. SysReady appears one cycle after MAck.
- **MAck gating:** MAck while MReq=0 is ignored.
- **Busy strobe:** SysStrobe outside IDLE is ignored; the controller never issues one.
- **Back-to-back strobe:** SysStrobe in the same cycle that the block returns to IDLE is not accepted; it must arrive while state=IDLE.
- **do_buffer_flush:** clears count, fill_valid and readup on the next edge. When it coincides with a read strobe in IDLE, the read is still accepted with count=0. In RD_BEAT it restarts the fill at offset 0 with MAddress=base.
- **Arithmetic:** MAddress arithmetic wraps modulo 2^ADDR_WIDTH. Because base is line-aligned, no carry ever crosses the line boundary.
- **Control outputs:** SysReady and readup are never asserted in the same cycle.

Decomposition:
- Shared defines include: `RW_READ, `RW_WRITE, `RW_UNK; these are the same definitions the cache controller uses.
- Local parameters: state encodings IDLE=2'd0, RD_BEAT=2'd1, WR_BEAT=2'd2.
- No sub-module; the beat counter and address generator stay inline in one flat module, about 150 lines.

Test Plan:
- **Line fill, no wait states:** read strobe at 0x0000_1234, MAck every cycle with MRData = 0xA0..0xA3.
  - MAddress = 0x1230, 0x1234, 0x1238, 0x123C.
  - fill_offset 0..3 with matching data.
  - readup high only with offset 3; MReq low afterwards.
- **Line fill with 2-cycle wait per beat:** MAddress and MReq hold across the waits; exactly 4 fill_valid pulses; readup 1 cycle after the 4th MAck.
- **Write-through:** write to 0x0000_0088 with data 0xDEADBEEF, MAck after 3 cycles.
  - MRw=`RW_WRITE, MAddress=0x88, MWData=0xDEADBEEF.
  - SysReady is a single pulse one cycle after MAck; no fill_valid.
- **Reset mid-fill:** reset after the 2nd beat. Next cycle MReq=0, count=0, no readup. A subsequent fill starts at offset 0.
- **do_buffer_flush during RD_BEAT after beat 1:** MAddress returns to base; fill restarts at offset 0; 4 further beats before readup.
- **Stray inputs:** MAck pulse in IDLE and SysStrobe during WR_BEAT. Required: no state change, no outputs, and the write completes normally.

Source files
------------

// File: rtl/cache_sys_if_pkg.sv
// +--------------------------------------------------------------------------+
// | cache_sys_if_pkg : shared read/write codes and state encoding for the     |
// |                    cache system-side bus interface.                       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef RW_READ
`define RW_READ  1'b1
`endif
`ifndef RW_WRITE
`define RW_WRITE 1'b0
`endif
// The bus direction line has no third level, so the idle code parks it at write.
`ifndef RW_UNK
`define RW_UNK   1'b0
`endif

package cache_sys_if_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BEAT = 2'd1,
        WR_BEAT = 2'd2
    } state_t;

    function automatic int byte_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_sys_if.sv
// +--------------------------------------------------------------------------+
// | cache_sys_if : turns cache-controller strobes into single-word memory    |
// |                beats (line fill on read miss, one write on write-through)|
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module cache_sys_if
    import cache_sys_if_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int OFS_WIDTH  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  SysStrobe,
    input  logic                  SysRW,
    input  logic [ADDR_WIDTH-1:0] SysAddress,
    input  logic [DATA_WIDTH-1:0] SysWData,
    input  logic                  do_buffer_flush,
    output logic                  SysReady,
    output logic                  readup,
    output logic                  fill_valid,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic [OFS_WIDTH-1:0]  fill_offset,
    output logic                  MReq,
    output logic                  MRw,
    output logic [ADDR_WIDTH-1:0] MAddress,
    output logic [DATA_WIDTH-1:0] MWData,
    input  logic [DATA_WIDTH-1:0] MRData,
    input  logic                  MAck
);

    localparam int                    c_byte_shift = byte_shift(DATA_WIDTH);
    localparam int                    c_line_shift = OFS_WIDTH + c_byte_shift;
    localparam logic [ADDR_WIDTH-1:0] c_line_mask  =
        ~((ADDR_WIDTH'(1) << c_line_shift) - ADDR_WIDTH'(1));
    localparam logic [OFS_WIDTH-1:0]  c_last_ofs   = OFS_WIDTH'(LINE_WORDS - 1);

    state_t                r_state, w_state;
    logic [OFS_WIDTH-1:0]  r_count, w_count;
    logic [ADDR_WIDTH-1:0] r_base,  w_base;

    logic                  w_mreq, w_mrw, w_sys_ready, w_readup, w_fill_valid;
    logic [ADDR_WIDTH-1:0] w_maddr;
    logic [DATA_WIDTH-1:0] w_mwdata, w_fill_data;
    logic [OFS_WIDTH-1:0]  w_fill_offset;

    logic [OFS_WIDTH-1:0]  w_next_ofs;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic                  w_ack;

    assign w_next_ofs  = r_count + OFS_WIDTH'(1);
    assign w_next_addr = r_base + (ADDR_WIDTH'(w_next_ofs) << c_byte_shift);
    assign w_ack       = MAck & MReq;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_base      <= '0;
            MReq        <= 1'b0;
            MRw         <= `RW_UNK;
            MAddress    <= '0;
            MWData      <= '0;
            SysReady    <= 1'b0;
            readup      <= 1'b0;
            fill_valid  <= 1'b0;
            fill_data   <= '0;
            fill_offset <= '0;
        end else begin
            r_state     <= w_state;
            r_count     <= w_count;
            r_base      <= w_base;
            MReq        <= w_mreq;
            MRw         <= w_mrw;
            MAddress    <= w_maddr;
            MWData      <= w_mwdata;
            SysReady    <= w_sys_ready;
            readup      <= w_readup;
            fill_valid  <= w_fill_valid;
            fill_data   <= w_fill_data;
            fill_offset <= w_fill_offset;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_count       = r_count;
        w_base        = r_base;
        w_mreq        = MReq;
        w_mrw         = MRw;
        w_maddr       = MAddress;
        w_mwdata      = MWData;
        w_sys_ready   = 1'b0;
        w_readup      = 1'b0;
        w_fill_valid  = 1'b0;
        w_fill_data   = fill_data;
        w_fill_offset = fill_offset;

        if (do_buffer_flush) begin
            w_count = '0;
        end

        case (r_state)
            IDLE: begin
                if (SysStrobe) begin
                    if (SysRW == `RW_READ) begin
                        w_base  = SysAddress & c_line_mask;
                        w_count = '0;
                        w_mreq  = 1'b1;
                        w_mrw   = `RW_READ;
                        w_maddr = SysAddress & c_line_mask;
                        w_state = RD_BEAT;
                    end else begin
                        w_mreq   = 1'b1;
                        w_mrw    = `RW_WRITE;
                        w_maddr  = SysAddress;
                        w_mwdata = SysWData;
                        w_state  = WR_BEAT;
                    end
                end
            end
            RD_BEAT: begin
                // A flush discards any beat acknowledged in the same cycle and restarts the line.
                if (do_buffer_flush) begin
                    w_maddr = r_base;
                end else if (w_ack) begin
                    w_fill_data   = MRData;
                    w_fill_offset = r_count;
                    w_fill_valid  = 1'b1;
                    if (r_count == c_last_ofs) begin
                        w_readup = 1'b1;
                        w_mreq   = 1'b0;
                        w_state  = IDLE;
                    end else begin
                        w_count = w_next_ofs;
                        w_maddr = w_next_addr;
                    end
                end
            end
            WR_BEAT: begin
                if (w_ack) begin
                    w_mreq      = 1'b0;
                    w_sys_ready = 1'b1;
                    w_state     = IDLE;
                end
            end
            default: begin
                w_mreq  = 1'b0;
                w_state = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_sys_if.sv
// +--------------------------------------------------------------------------+
// | tb_cache_sys_if : randomized self-checking bench for cache_sys_if        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

`ifndef RW_READ
`define RW_READ  1'b1
`endif
`ifndef RW_WRITE
`define RW_WRITE 1'b0
`endif
`ifndef RW_UNK
`define RW_UNK   1'b0
`endif

module tb_cache_sys_if;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int OW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          SysStrobe = 1'b0;
    logic          SysRW = `RW_READ;
    logic [AW-1:0] SysAddress = '0;
    logic [DW-1:0] SysWData = '0;
    logic          do_buffer_flush = 1'b0;
    logic          SysReady, readup, fill_valid, MReq, MRw;
    logic [DW-1:0] fill_data, MWData;
    logic [OW-1:0] fill_offset;
    logic [AW-1:0] MAddress;
    logic [DW-1:0] MRData = '0;
    logic          MAck = 1'b0;

    int total = 0;
    int bad   = 0;

    cache_sys_if #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW), .OFS_WIDTH(OW)
    ) dut (
        .clock(clock), .reset(reset),
        .SysStrobe(SysStrobe), .SysRW(SysRW), .SysAddress(SysAddress), .SysWData(SysWData),
        .do_buffer_flush(do_buffer_flush),
        .SysReady(SysReady), .readup(readup),
        .fill_valid(fill_valid), .fill_data(fill_data), .fill_offset(fill_offset),
        .MReq(MReq), .MRw(MRw), .MAddress(MAddress), .MWData(MWData),
        .MRData(MRData), .MAck(MAck)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_read(input logic [31:0] addr, input bit flush);
        SysStrobe       = 1'b1;
        SysRW           = `RW_READ;
        SysAddress      = addr;
        do_buffer_flush = flush;
        step();
        SysStrobe       = 1'b0;
        do_buffer_flush = 1'b0;
        SysAddress      = $urandom;
    endtask

    // One line-fill word: expected address is the line base plus the word's byte offset.
    task automatic read_beat(input logic [31:0] base, input int b, input int waits,
                             input logic [31:0] data);
        for (int i = 0; i <= waits; i++) begin
            check_eq("rd_mreq", MReq, 1);
            check_eq("rd_mrw", MRw, `RW_READ);
            check_eq("rd_addr", MAddress, base + 32'(b * (DW / 8)));
            MAck   = (i == waits);
            MRData = (i == waits) ? data : $urandom;
            step();
            MAck   = 1'b0;
            check_eq("rd_fill_valid", fill_valid, (i == waits) ? 1 : 0);
            check_eq("rd_sysready", SysReady, 0);
            if (i == waits) begin
                check_eq("rd_offset", fill_offset, b);
                check_eq("rd_data", fill_data, data);
                check_eq("rd_readup", readup, (b == LW - 1) ? 1 : 0);
            end else begin
                check_eq("rd_readup_wait", readup, 0);
            end
        end
    endtask

    task automatic read_line(input logic [31:0] addr, input int maxw, input logic [31:0] d0,
                             input bit flush);
        logic [31:0] base;
        base = addr & 32'hFFFF_FFF0;
        start_read(addr, flush);
        for (int b = 0; b < LW; b++) begin
            read_beat(base, b, $urandom_range(0, maxw), d0 + 32'(b));
        end
        check_eq("rd_done_mreq", MReq, 0);
        step();
        check_eq("rd_after_fv", fill_valid, 0);
        check_eq("rd_after_readup", readup, 0);
        check_eq("rd_after_mreq", MReq, 0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int waits,
                            input bit stray);
        SysStrobe  = 1'b1;
        SysRW      = `RW_WRITE;
        SysAddress = addr;
        SysWData   = data;
        step();
        SysStrobe  = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            check_eq("wr_mreq", MReq, 1);
            check_eq("wr_mrw", MRw, `RW_WRITE);
            check_eq("wr_addr", MAddress, addr);
            check_eq("wr_wdata", MWData, data);
            check_eq("wr_fill_valid", fill_valid, 0);
            check_eq("wr_sysready_wait", SysReady, 0);
            if (stray && i == 0 && waits > 0) begin
                SysStrobe  = 1'b1;
                SysRW      = 1'($urandom);
                SysAddress = $urandom;
                SysWData   = $urandom;
            end
            MAck = (i == waits);
            step();
            MAck      = 1'b0;
            SysStrobe = 1'b0;
        end
        check_eq("wr_sysready", SysReady, 1);
        check_eq("wr_done_mreq", MReq, 0);
        check_eq("wr_done_fv", fill_valid, 0);
        check_eq("wr_done_readup", readup, 0);
        step();
        check_eq("wr_sysready_once", SysReady, 0);
        check_eq("wr_idle_mreq", MReq, 0);
    endtask

    task automatic stray_ack();
        MAck   = 1'b1;
        MRData = $urandom;
        step();
        MAck   = 1'b0;
        check_eq("idle_ack_mreq", MReq, 0);
        check_eq("idle_ack_fv", fill_valid, 0);
        check_eq("idle_ack_ready", SysReady, 0);
        check_eq("idle_ack_readup", readup, 0);
    endtask

    initial begin
        logic [31:0] base;
        logic [31:0] addr;

        reset = 1'b1;
        step();
        step();
        check_eq("rst_mreq", MReq, 0);
        check_eq("rst_mrw", MRw, `RW_UNK);
        check_eq("rst_maddr", MAddress, 0);
        check_eq("rst_mwdata", MWData, 0);
        check_eq("rst_fill_data", fill_data, 0);
        check_eq("rst_fill_offset", fill_offset, 0);
        check_eq("rst_flags", {29'd0, fill_valid, readup, SysReady}, 0);
        reset = 1'b0;
        step();

        // Zero-wait fill at 0x1234 with words 0xA0..0xA3.
        read_line(32'h0000_1234, 0, 32'h0000_00A0, 1'b0);
        // Two wait states per beat.
        start_read(32'h0000_2008, 1'b0);
        for (int b = 0; b < LW; b++) read_beat(32'h0000_2000, b, 2, 32'h0000_00B0 + 32'(b));
        step();
        // Write-through with MAck after three cycles and a stray strobe.
        do_write(32'h0000_0088, 32'hDEAD_BEEF, 3, 1'b1);
        stray_ack();

        // Reset after the second beat aborts the fill with no late pulses.
        start_read(32'h4000_0050, 1'b0);
        read_beat(32'h4000_0050, 0, 0, 32'h1111_0000);
        read_beat(32'h4000_0050, 1, 1, 32'h1111_0001);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("midrst_mreq", MReq, 0);
        check_eq("midrst_readup", readup, 0);
        check_eq("midrst_fv", fill_valid, 0);
        check_eq("midrst_maddr", MAddress, 0);
        step();
        check_eq("midrst_late_readup", readup, 0);
        check_eq("midrst_late_fv", fill_valid, 0);
        read_line(32'h4000_0050, 1, 32'h2222_0000, 1'b0);

        // Flush after beat 0 restarts the line at the base address.
        addr = 32'hFFFF_FFFC;
        base = addr & 32'hFFFF_FFF0;
        start_read(addr, 1'b0);
        read_beat(base, 0, 1, 32'h3333_0000);
        do_buffer_flush = 1'b1;
        step();
        do_buffer_flush = 1'b0;
        check_eq("flush_maddr", MAddress, base);
        check_eq("flush_mreq", MReq, 1);
        check_eq("flush_fv", fill_valid, 0);
        check_eq("flush_readup", readup, 0);
        for (int b = 0; b < LW; b++) read_beat(base, b, $urandom_range(0, 2), 32'h4444_0000 + 32'(b));
        step();

        // Randomized mix of fills, writes, idle acks and idle gaps.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0, 1: read_line($urandom, $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
                2:    do_write($urandom, $urandom, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
                default: stray_ack();
            endcase
            repeat ($urandom_range(0, 2)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
